s_pe_out_stream: RTL and testbench

Streaming output collector for the Mage PEA in streaming mode, sitting directly downstream of an edge processing element. It captures the PE's registered result on every cycle where the PE output is valid and the array advances. It buffers results in a small FIFO and replays them on a valid/ready master stream with a programmable word count. It returns a ready contribution that the PEA ANDs into the global `pea_ready`, so the array stalls instead of dropping results.

---
 rtl/pea_pkg.sv | 14 +
 rtl/s_stream_fifo.sv | 72 +++++++
 rtl/s_pe_out_stream.sv | 158 +++++++++++++++
 tb/tb_s_pe_out_stream.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pea_pkg.sv
// Shared definitions for the Mage PEA: datapath width and the output
// stream collector state encoding.
package pea_pkg;

  localparam int N_BITS = 32;

  typedef enum logic [1:0] {
    OS_IDLE  = 2'd0,
    OS_RUN   = 2'd1,
    OS_DRAIN = 2'd2,
    OS_DONE  = 2'd3
  } out_stream_state_t;

endpackage

// File: rtl/s_stream_fifo.sv
// Small flop-based FIFO whose head word is read straight from storage flops,
// so the output has no combinational path from data_i.
module s_stream_fifo #(
  parameter int N_BITS = 32,
  parameter int DEPTH  = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   push_i,
  input  logic [N_BITS-1:0]      data_i,
  input  logic                   pop_i,
  output logic [N_BITS-1:0]      data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [N_BITS-1:0] mem_q [DEPTH];
  logic [N_BITS-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push_s, pop_s;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == {CNT_W{1'b0}});
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A push while full is only taken when the same cycle frees a slot.
  always_comb begin
    push_s   = push_i && (!full_o || pop_i);
    pop_s    = pop_i && !empty_o;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/s_pe_out_stream.sv
// Streaming output collector behind an edge PE: captures PE results into a FIFO
// and replays len words on a valid/ready stream. Optional: MAGE_OUT_STALL_CNT_EN.
module s_pe_out_stream
  import pea_pkg::*;
#(
  parameter int N_BITS = pea_pkg::N_BITS,
  parameter int DEPTH  = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              mage_done_i,
  input  logic              start_i,
  input  logic [15:0]       len_i,
  input  logic [N_BITS-1:0] pe_res_i,
  input  logic              pe_valid_i,
  input  logic              pea_ready_i,
  output logic              out_ready_o,
  output logic [N_BITS-1:0] m_data_o,
  output logic              m_valid_o,
  output logic              m_last_o,
  input  logic              m_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [31:0]       stall_cycles_o
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  out_stream_state_t state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       cap_cnt_q, cap_cnt_d;
  logic [15:0]       pop_cnt_q, pop_cnt_d;
  logic              push_s, pop_s;
  logic              fifo_full_s, fifo_empty_s;
  logic [CNT_W-1:0]  fifo_count_s;
  logic [N_BITS-1:0] fifo_data_s;

  s_stream_fifo #(
    .N_BITS (N_BITS),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (push_s),
    .data_i  (pe_res_i),
    .pop_i   (pop_s),
    .data_o  (fifo_data_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (fifo_count_s)
  );

  assign m_valid_o   = !fifo_empty_s;
  assign m_data_o    = fifo_data_s;
  assign pop_s       = m_valid_o && m_ready_i;
  assign out_ready_o = (state_q == OS_RUN) && !fifo_full_s;
  assign m_last_o    = m_valid_o && (pop_cnt_q == len_q - 16'd1);
  assign busy_o      = (state_q != OS_IDLE);
  assign done_o      = (state_q == OS_DONE);

  // An early kernel-done shrinks len to the captured count so the last
  // buffered word carries the last marker.
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cap_cnt_d = cap_cnt_q;
    pop_cnt_d = pop_cnt_q;
    push_s    = 1'b0;
    if (pop_s) begin
      pop_cnt_d = pop_cnt_q + 16'd1;
    end else begin
      pop_cnt_d = pop_cnt_q;
    end
    case (state_q)
      OS_IDLE: begin
        if (start_i && (len_i != 16'd0)) begin
          state_d   = OS_RUN;
          len_d     = len_i;
          cap_cnt_d = 16'd0;
          pop_cnt_d = 16'd0;
        end else if (start_i) begin
          state_d = OS_DONE;
        end else begin
          state_d = OS_IDLE;
        end
      end
      OS_RUN: begin
        if (mage_done_i) begin
          state_d = OS_DRAIN;
          len_d   = cap_cnt_q;
        end else if (pe_valid_i && pea_ready_i && out_ready_o) begin
          push_s    = 1'b1;
          cap_cnt_d = cap_cnt_q + 16'd1;
          if (cap_cnt_d == len_q) begin
            state_d = OS_DRAIN;
          end else begin
            state_d = OS_RUN;
          end
        end else begin
          state_d = OS_RUN;
        end
      end
      OS_DRAIN: begin
        if (fifo_empty_s || ((fifo_count_s == CNT_W'(1)) && pop_s)) begin
          state_d = OS_DONE;
        end else begin
          state_d = OS_DRAIN;
        end
      end
      OS_DONE: state_d = OS_IDLE;
      default: state_d = OS_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= OS_IDLE;
      len_q     <= 16'd0;
      cap_cnt_q <= 16'd0;
      pop_cnt_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      cap_cnt_q <= cap_cnt_d;
      pop_cnt_q <= pop_cnt_d;
    end
  end

`ifdef MAGE_OUT_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  // Saturating count of sink-stalled cycles while a run is active.
  always_comb begin
    stall_d = stall_q;
    if ((state_q == OS_IDLE) && start_i && (len_i != 16'd0)) begin
      stall_d = 32'd0;
    end else if (((state_q == OS_RUN) || (state_q == OS_DRAIN)) && m_valid_o &&
                 !m_ready_i && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end else begin
      stall_d = stall_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_q <= 32'd0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles_o = stall_q;
`else
  assign stall_cycles_o = 32'd0;
`endif

endmodule

// File: tb/tb_s_pe_out_stream.sv
// Scoreboard bench for s_pe_out_stream: directed runs push expected words,
// a negedge monitor pops and compares every stream handshake.
module tb_s_pe_out_stream;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mage_done = 1'b0;
  logic        start = 1'b0;
  logic [15:0] len = 16'd0;
  logic [31:0] pe_res = 32'd0;
  logic        pe_valid = 1'b0;
  logic        other_ready = 1'b1;
  logic        pea_ready;
  logic        out_ready;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_last;
  logic        m_ready = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] stall_cycles;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_pop_cyc = 0;
  int   prod_n = 0;

  assign pea_ready = out_ready & other_ready;

  s_pe_out_stream dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .mage_done_i    (mage_done),
    .start_i        (start),
    .len_i          (len),
    .pe_res_i       (pe_res),
    .pe_valid_i     (pe_valid),
    .pea_ready_i    (pea_ready),
    .out_ready_o    (out_ready),
    .m_data_o       (m_data),
    .m_valid_o      (m_valid),
    .m_last_o       (m_last),
    .m_ready_i      (m_ready),
    .busy_o         (busy),
    .done_o         (done),
    .stall_cycles_o (stall_cycles)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Monitor: every accepted stream word is compared against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && m_valid && m_ready) begin
        last_pop_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_word", {32'd0, m_data}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("stream_data", {32'd0, m_data}, {32'd0, e.data});
          check("stream_last", {63'd0, m_last}, {63'd0, e.last});
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int n, input logic [31:0] base, input logic [31:0] step);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.data = base + step * 32'(i);
      e.last = (i == n - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic do_start(input logic [15:0] l);
    start = 1'b1;
    len   = l;
    tick();
    start = 1'b0;
  endtask

  // Models the PE: holds each result until the array accepts it.
  task automatic produce(input int n, input logic [31:0] base, input logic [31:0] step);
    int  guard = 0;
    bit  fire;
    prod_n = 0;
    while (prod_n < n && guard < 300) begin
      pe_valid = 1'b1;
      pe_res   = base + step * 32'(prod_n);
      @(negedge clk);
      fire = pea_ready && pe_valid && !mage_done;
      tick();
      if (fire) prod_n++;
      guard++;
    end
    pe_valid = 1'b0;
    if (prod_n < n) check("produce_timeout", 64'(prod_n), 64'(n));
  endtask

  task automatic wait_done(input bit chk_lat);
    bit found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (done) found = 1'b1;
    end
    check("done_seen", {63'd0, found}, 64'd1);
    if (found) begin
      if (chk_lat) check("done_latency", 64'(cyc - last_pop_cyc), 64'd1);
      @(negedge clk);
      check("done_one_cycle", {63'd0, done}, 64'd0);
      check("idle_after_done", {63'd0, busy}, 64'd0);
    end
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    tick();
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    check("rst_out_ready", {63'd0, out_ready}, 64'd0);
    check("rst_m_valid", {63'd0, m_valid}, 64'd0);
    check("rst_m_last", {63'd0, m_last}, 64'd0);
    check("rst_m_data", {32'd0, m_data}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_stall", {32'd0, stall_cycles}, 64'd0);
    rst_n = 1'b1;
    tick();

    // Basic run, len 5, sink always ready
    m_ready = 1'b1;
    push_exp(5, 32'h11, 32'h1);
    do_start(16'd5);
    check("basic_ready_after_start", {63'd0, out_ready}, 64'd1);
    check("basic_busy", {63'd0, busy}, 64'd1);
    produce(5, 32'h11, 32'h1);
    check("basic_ready_low_at_len", {63'd0, out_ready}, 64'd0);
    wait_done(1'b1);

    // Sink backpressure, len 10 into a 4-deep FIFO
    m_ready = 1'b0;
    push_exp(10, 32'h100, 32'h3);
    do_start(16'd10);
    fork
      produce(10, 32'h100, 32'h3);
      begin
        repeat (8) tick();
        @(negedge clk);
        check("bp_captures_when_full", 64'(prod_n), 64'd4);
        check("bp_out_ready_low", {63'd0, out_ready}, 64'd0);
        check("bp_pea_ready_low", {63'd0, pea_ready}, 64'd0);
        check("bp_m_valid", {63'd0, m_valid}, 64'd1);
`ifdef MAGE_OUT_STALL_CNT_EN
        check("bp_stall_min7", {63'd0, (stall_cycles >= 32'd7)}, 64'd1);
`else
        check("bp_stall_tied0", {32'd0, stall_cycles}, 64'd0);
`endif
        tick();
        m_ready = 1'b1;
      end
    join
    wait_done(1'b1);

    // Held PE result while the array stalls
    other_ready = 1'b0;
    push_exp(1, 32'hA5, 32'h0);
    exp_q[0].last = 1'b0;
    push_exp(1, 32'h1A5, 32'h0);
    do_start(16'd2);
    fork
      produce(2, 32'hA5, 32'h100);
      begin
        repeat (3) tick();
        other_ready = 1'b1;
      end
    join
    wait_done(1'b1);

    // Early termination after 3 of 8 captures; the done cycle's word is dropped
    m_ready = 1'b0;
    push_exp(3, 32'h300, 32'h1);
    do_start(16'd8);
    produce(3, 32'h300, 32'h1);
    pe_valid  = 1'b1;
    pe_res    = 32'hBAD;
    mage_done = 1'b1;
    tick();
    mage_done = 1'b0;
    pe_valid  = 1'b0;
    check("early_out_ready_low", {63'd0, out_ready}, 64'd0);
    m_ready = 1'b1;
    wait_done(1'b1);

    // Zero length
    do_start(16'd0);
    check("zero_done", {63'd0, done}, 64'd1);
    check("zero_out_ready", {63'd0, out_ready}, 64'd0);
    check("zero_m_valid", {63'd0, m_valid}, 64'd0);
    tick();
    check("zero_done_pulse", {63'd0, done}, 64'd0);
    check("zero_idle", {63'd0, busy}, 64'd0);

    // Reset mid-run with two words buffered
    m_ready = 1'b0;
    do_start(16'd4);
    produce(2, 32'h77, 32'h1);
    check("midrst_buffered", {63'd0, m_valid}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_m_valid", {63'd0, m_valid}, 64'd0);
    check("midrst_m_data", {32'd0, m_data}, 64'd0);
    check("midrst_m_last", {63'd0, m_last}, 64'd0);
    check("midrst_out_ready", {63'd0, out_ready}, 64'd0);
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_done", {63'd0, done}, 64'd0);
    check("midrst_stall", {32'd0, stall_cycles}, 64'd0);
    tick();
    rst_n   = 1'b1;
    m_ready = 1'b1;
    tick();
    push_exp(2, 32'hC0DE_0001, 32'h1);
    do_start(16'd2);
    produce(2, 32'hC0DE_0001, 32'h1);
    wait_done(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
